// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs, ALU ops, FSM states.
// The JR state exists only when MIPS_CTRL_JR_EN is defined.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
`ifdef MIPS_CTRL_JR_EN
        S_JR       = 4'd13,
`endif
        S_TRAP     = 4'd14
    } state_t;

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational funct decode for R-type instructions: ALU operation, valid flag and jr detect.
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       valid,
    output logic       is_jr
);

    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: valid  = 1'b0;
        endcase
    end

    assign is_jr = (funct == FN_JR);

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS control FSM with memory ready handshake and sticky illegal-instruction trap.
// Build option MIPS_CTRL_JR_EN adds the JR state; without it funct 0x08 traps and jr stays 0.
module mips_ctrl_fsm
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       reg_dst,
    output logic       reg_wr,
    output logic [2:0] alu_op,
    output logic       alusrc,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       mem2reg,
    output logic       branch,
    output logic       jump,
    output logic       jr,
    output logic       instr_done,
    output logic       illegal
);

    state_t     state;
    state_t     state_nx;
    logic [2:0] dec_op;
    logic       dec_valid;
    logic       dec_jr;
    logic [2:0] alu_op_q;
    logic       is_sw_q;

    // The branch decision on zero is taken in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    mips_alu_decode u_alu_decode (
        .funct  (funct),
        .alu_op (dec_op),
        .valid  (dec_valid),
        .is_jr  (dec_jr)
    );

    // opcode/funct are only valid in DECODE and EX, so keep what later states need.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            alu_op_q <= ALU_ADD;
            is_sw_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) is_sw_q <= (opcode == OP_SW);
            if (state == S_RTYPE_EX) alu_op_q <= dec_op;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     state_nx = S_FETCH;
            S_FETCH:    if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (dec_valid) state_nx = S_RTYPE_EX;
`ifdef MIPS_CTRL_JR_EN
                        else if (dec_jr) state_nx = S_JR;
`else
                        else if (dec_jr) state_nx = S_TRAP;
`endif
                        else state_nx = S_TRAP;
                    end
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_J:         state_nx = S_JUMP;
                    OP_ADDI:      state_nx = S_ADDI_EX;
                    default:      state_nx = S_TRAP;
                endcase
            end
            S_MEMADR:   state_nx = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (mem_ready) state_nx = S_MEMWB;
            S_MEMWB:    state_nx = S_FETCH;
            S_MEMWR:    if (mem_ready) state_nx = S_FETCH;
            S_RTYPE_EX: state_nx = S_RTYPE_WB;
            S_RTYPE_WB: state_nx = S_FETCH;
            S_ADDI_EX:  state_nx = S_ADDI_WB;
            S_ADDI_WB:  state_nx = S_FETCH;
            S_BRANCH:   state_nx = S_FETCH;
            S_JUMP:     state_nx = S_FETCH;
`ifdef MIPS_CTRL_JR_EN
            S_JR:       state_nx = S_FETCH;
`endif
            S_TRAP:     state_nx = S_TRAP;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_dst    = 1'b0;
        reg_wr     = 1'b0;
        alu_op     = ALU_ADD;
        alusrc     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem2reg    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jr         = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_rd = 1'b1;
                pc_wr  = mem_ready;
                ir_wr  = mem_ready;
            end
            S_MEMADR, S_ADDI_EX: alusrc = 1'b1;
            S_MEMRD: begin
                mem_rd = 1'b1;
                alusrc = 1'b1;
            end
            S_MEMWB: begin
                reg_wr     = 1'b1;
                reg_dst    = 1'b1;
                mem2reg    = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_wr     = 1'b1;
                alusrc     = 1'b1;
                instr_done = mem_ready;
            end
            S_RTYPE_EX: alu_op = dec_op;
            S_RTYPE_WB: begin
                reg_wr     = 1'b1;
                alu_op     = alu_op_q;
                instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                reg_wr     = 1'b1;
                reg_dst    = 1'b1;
                alusrc     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                branch     = 1'b1;
                alu_op     = ALU_SUB;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                jump       = 1'b1;
                instr_done = 1'b1;
            end
`ifdef MIPS_CTRL_JR_EN
            S_JR: begin
                jr         = 1'b1;
                instr_done = 1'b1;
            end
`endif
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed-vector bench for mips_ctrl_fsm: per-cycle output vectors with hand-computed expectations.
module tb_mips_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_wr, ir_wr, reg_dst, reg_wr, alusrc, mem_rd, mem_wr, mem2reg;
    logic       branch, jump, jr, instr_done, illegal;
    logic [2:0] alu_op;
    logic [15:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_ctrl_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_wr      (pc_wr),
        .ir_wr      (ir_wr),
        .reg_dst    (reg_dst),
        .reg_wr     (reg_wr),
        .alu_op     (alu_op),
        .alusrc     (alusrc),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem2reg    (mem2reg),
        .branch     (branch),
        .jump       (jump),
        .jr         (jr),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    // {pc_wr, ir_wr, reg_dst, reg_wr, alu_op[2:0], alusrc, mem_rd, mem_wr, mem2reg, branch, jump, jr, instr_done, illegal}
    assign outs = {pc_wr, ir_wr, reg_dst, reg_wr, alu_op, alusrc, mem_rd, mem_wr,
                   mem2reg, branch, jump, jr, instr_done, illegal};

    localparam logic [15:0] E_ZERO    = 16'h0000;
    localparam logic [15:0] E_FETCH   = {4'b1100, 3'b000, 9'b0_1000_0000};
    localparam logic [15:0] E_FWAIT   = {4'b0000, 3'b000, 9'b0_1000_0000};
    localparam logic [15:0] E_ADDR    = {4'b0000, 3'b000, 9'b1_0000_0000};
    localparam logic [15:0] E_MEMRD   = {4'b0000, 3'b000, 9'b1_1000_0000};
    localparam logic [15:0] E_MEMWB   = {4'b0011, 3'b000, 9'b0_0010_0010};
    localparam logic [15:0] E_MEMWR   = {4'b0000, 3'b000, 9'b1_0100_0000};
    localparam logic [15:0] E_MEMWR_D = {4'b0000, 3'b000, 9'b1_0100_0010};
    localparam logic [15:0] E_ADDI_WB = {4'b0011, 3'b000, 9'b1_0000_0010};
    localparam logic [15:0] E_BRANCH  = {4'b0000, 3'b001, 9'b0_0001_0010};
    localparam logic [15:0] E_JUMP    = {4'b0000, 3'b000, 9'b0_0000_1010};
    localparam logic [15:0] E_JR      = {4'b0000, 3'b000, 9'b0_0000_0110};
    localparam logic [15:0] E_TRAP    = {4'b0000, 3'b000, 9'b0_0000_0001};

    function automatic logic [15:0] e_rex(input logic [2:0] aop);
        return {4'b0000, aop, 9'b0};
    endfunction

    function automatic logic [15:0] e_rwb(input logic [2:0] aop);
        return {4'b0001, aop, 9'b0_0000_0010};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, then check the outputs of the current state.
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                        input logic [15:0] exp, input string tag);
        @(negedge clk);
        opcode    = op;
        funct     = fn;
        mem_ready = rdy;
        #1;
        check(tag, {16'h0, outs}, {16'h0, exp});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_outs", {16'h0, outs}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_outs", {16'h0, outs}, 32'h0);
    endtask

    task automatic run_rtype(input logic [5:0] fn, input logic [2:0] aop, input string tag);
        step(6'h00, fn, 1'b1, E_FETCH, {tag, "_fetch"});
        step(6'h00, fn, 1'b1, E_ZERO, {tag, "_decode"});
        step(6'h00, fn, 1'b1, e_rex(aop), {tag, "_ex"});
        step(6'h00, fn, 1'b1, e_rwb(aop), {tag, "_wb"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // lw, no waits: 5 cycles FETCH..MEMWB
        step(6'h23, 6'h00, 1'b1, E_FETCH, "lw_fetch");
        step(6'h23, 6'h00, 1'b1, E_ZERO,  "lw_decode");
        step(6'h23, 6'h00, 1'b1, E_ADDR,  "lw_memadr");
        step(6'h23, 6'h00, 1'b1, E_MEMRD, "lw_memrd");
        step(6'h23, 6'h00, 1'b1, E_MEMWB, "lw_memwb");

        run_rtype(6'h22, 3'b001, "sub");
        run_rtype(6'h20, 3'b000, "add");
        run_rtype(6'h24, 3'b010, "and");
        run_rtype(6'h25, 3'b011, "or");
        run_rtype(6'h2A, 3'b100, "slt");

        // sw with 3 wait cycles in MEMWR: 7 cycles total
        step(6'h2B, 6'h00, 1'b1, E_FETCH,   "sw_fetch");
        step(6'h2B, 6'h00, 1'b1, E_ZERO,    "sw_decode");
        step(6'h2B, 6'h00, 1'b1, E_ADDR,    "sw_memadr");
        for (int i = 0; i < 3; i++)
            step(6'h2B, 6'h00, 1'b0, E_MEMWR, "sw_wait");
        step(6'h2B, 6'h00, 1'b1, E_MEMWR_D, "sw_done");

        // addi with 2 fetch wait cycles
        step(6'h08, 6'h00, 1'b0, E_FWAIT,   "addi_fwait0");
        step(6'h08, 6'h00, 1'b0, E_FWAIT,   "addi_fwait1");
        step(6'h08, 6'h00, 1'b1, E_FETCH,   "addi_fetch");
        step(6'h08, 6'h00, 1'b1, E_ZERO,    "addi_decode");
        step(6'h08, 6'h00, 1'b1, E_ADDR,    "addi_ex");
        step(6'h08, 6'h00, 1'b1, E_ADDI_WB, "addi_wb");

        // beq and j: 3 cycles each
        step(6'h04, 6'h00, 1'b1, E_FETCH,  "beq_fetch");
        step(6'h04, 6'h00, 1'b1, E_ZERO,   "beq_decode");
        step(6'h04, 6'h00, 1'b1, E_BRANCH, "beq_branch");
        step(6'h02, 6'h00, 1'b1, E_FETCH,  "j_fetch");
        step(6'h02, 6'h00, 1'b1, E_ZERO,   "j_decode");
        step(6'h02, 6'h00, 1'b1, E_JUMP,   "j_jump");

        // funct 0x08 under opcode 0
        step(6'h00, 6'h08, 1'b1, E_FETCH, "jr_fetch");
        step(6'h00, 6'h08, 1'b1, E_ZERO,  "jr_decode");
`ifdef MIPS_CTRL_JR_EN
        step(6'h00, 6'h08, 1'b1, E_JR,    "jr_jr");
        step(6'h00, 6'h08, 1'b1, E_FETCH, "jr_next_fetch");
        step(6'h00, 6'h08, 1'b1, E_ZERO,  "jr_next_decode");
        step(6'h00, 6'h08, 1'b1, E_JR,    "jr_jr2");
`else
        step(6'h00, 6'h08, 1'b1, E_TRAP,  "jr_trap");
        step(6'h00, 6'h20, 1'b1, E_TRAP,  "jr_trap_hold");
        do_reset();
`endif

        // invalid funct under opcode 0 traps
`ifdef MIPS_CTRL_JR_EN
        step(6'h00, 6'h3F, 1'b1, E_FETCH, "badfn_fetch");
`else
        step(6'h00, 6'h3F, 1'b1, E_FETCH, "badfn_fetch");
`endif
        step(6'h00, 6'h3F, 1'b1, E_ZERO,  "badfn_decode");
        step(6'h00, 6'h3F, 1'b1, E_TRAP,  "badfn_trap");
        do_reset();

        // reset during a MEMRD wait drops mem_rd immediately
        step(6'h23, 6'h00, 1'b1, E_FETCH, "rstw_fetch");
        step(6'h23, 6'h00, 1'b1, E_ZERO,  "rstw_decode");
        step(6'h23, 6'h00, 1'b1, E_ADDR,  "rstw_memadr");
        step(6'h23, 6'h00, 1'b0, E_MEMRD, "rstw_wait0");
        step(6'h23, 6'h00, 1'b0, E_MEMRD, "rstw_wait1");
        #2;
        rst = 1'b1;
        #1;
        check("rstw_async_outs", {16'h0, outs}, 32'h0);
        check("rstw_async_mem_rd", {31'h0, mem_rd}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstw_idle", {16'h0, outs}, 32'h0);
        step(6'h23, 6'h00, 1'b1, E_FETCH, "rstw_resume_fetch");
        step(6'h23, 6'h00, 1'b1, E_ZERO,  "rstw_resume_decode");
        step(6'h23, 6'h00, 1'b1, E_ADDR,  "rstw_resume_memadr");
        step(6'h23, 6'h00, 1'b1, E_MEMRD, "rstw_resume_memrd");
        step(6'h23, 6'h00, 1'b1, E_MEMWB, "rstw_resume_memwb");

        // illegal opcode: sticky trap for 10 cycles, inputs ignored
        step(6'h3F, 6'h00, 1'b1, E_FETCH, "trap_fetch");
        step(6'h3F, 6'h00, 1'b1, E_ZERO,  "trap_decode");
        for (int i = 0; i < 10; i++)
            step((i % 2 == 0) ? 6'h23 : 6'h00, 6'h20, i[0], E_TRAP, "trap_hold");
        #2;
        rst = 1'b1;
        #1;
        check("trap_rst_clears", {31'h0, illegal}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("trap_idle", {16'h0, outs}, 32'h0);
        step(6'h02, 6'h00, 1'b1, E_FETCH, "post_trap_fetch");
        step(6'h02, 6'h00, 1'b1, E_ZERO,  "post_trap_decode");
        step(6'h02, 6'h00, 1'b1, E_JUMP,  "post_trap_jump");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
